// File: rtl/mdc_frame_sched.sv
// Frame scheduler for the 32-point radix-4 MDC FFT: admits credit-gated input frames,
// emits per-stage start pulses from a start-event delay line and frames the fixed-latency output.
module mdc_frame_sched #(
  parameter int BEATS     = 8,
  parameter int LATENCY   = 26,
  parameter int ROM0_OFS  = 3,
  parameter int COMM0_OFS = 7,
  parameter int ROM1_OFS  = 17,
  parameter int COMM1_OFS = 21,
  parameter int CREDITS   = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             start_mdc_o,
  output logic             wrom0_start_o,
  output logic             comm0_start_o,
  output logic             wrom1_start_o,
  output logic             comm1_start_o,
  output logic             out_valid_o,
  output logic             out_first_o,
  output logic             out_last_o,
  output logic [TAG_W-1:0] out_tag_o,
  input  logic             credit_return_i,
  input  logic             err_clr_i,
  output logic             gap_err_o,
  output logic             credit_err_o,
  output logic             busy_o
);

  localparam int DL  = LATENCY + BEATS;
  localparam int CW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CRW = 4;
  localparam int FAW = 3;
  localparam int FD  = 1 << FAW;

  typedef enum logic {IDLE, FRAME} state_e;

  state_e              state_q;
  logic [CW-1:0]       beat_cnt_q;
  logic [CRW-1:0]      credits_q, credits_d;
  logic [DL-1:1]       dly_q;
  logic [TAG_W-1:0]    tag_in_q;
  logic [FD-1:0][TAG_W-1:0] tag_mem_q;
  logic [FAW-1:0]      wr_ptr_q, rd_ptr_q;
  logic                gap_set, cred_set;
  logic                gap_err_q, credit_err_q;

  // Admission is only possible from IDLE; start is combinational so the pipeline
  // sees the first beat and its start pulse together.
  assign in_ready_o  = (state_q == FRAME) | (credits_q != '0);
  assign start_mdc_o = rst_ni & (state_q == IDLE) & in_valid_i & (credits_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_mdc_o) begin
          state_q    <= FRAME;
          beat_cnt_q <= CW'(1);
        end
        FRAME: begin
          // Fixed pipeline timing: a frame occupies exactly BEATS slots, valid or not.
          if (beat_cnt_q == CW'(BEATS - 1)) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
          end else begin
            beat_cnt_q <= beat_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          beat_cnt_q <= '0;
        end
      endcase
    end
  end

  assign cred_set = credit_return_i & ~start_mdc_o & (credits_q == CRW'(CREDITS));
  assign gap_set  = (state_q == FRAME) & ~in_valid_i;

  always_comb begin
    credits_d = credits_q;
    if (start_mdc_o && !credit_return_i)
      credits_d = credits_q - CRW'(1);
    else if (credit_return_i && !start_mdc_o && !cred_set)
      credits_d = credits_q + CRW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credits_q    <= CRW'(CREDITS);
      gap_err_q    <= 1'b0;
      credit_err_q <= 1'b0;
    end else begin
      credits_q <= credits_d;
      if (gap_set)        gap_err_q <= 1'b1;
      else if (err_clr_i) gap_err_q <= 1'b0;
      if (cred_set)          credit_err_q <= 1'b1;
      else if (err_clr_i)    credit_err_q <= 1'b0;
    end
  end

  assign gap_err_o    = gap_err_q;
  assign credit_err_o = credit_err_q;

  // dly_q[k] is set k cycles after a frame start; bit 0 of the line is start_mdc_o itself.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) dly_q <= '0;
    else         dly_q <= {dly_q[DL-2:1], start_mdc_o};
  end

  assign wrom0_start_o = dly_q[ROM0_OFS];
  assign comm0_start_o = dly_q[COMM0_OFS];
  assign wrom1_start_o = dly_q[ROM1_OFS];
  assign comm1_start_o = dly_q[COMM1_OFS];
  assign out_valid_o   = |dly_q[DL-1:LATENCY];
  assign out_first_o   = dly_q[LATENCY];
  assign out_last_o    = dly_q[DL-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_in_q  <= '0;
      tag_mem_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      if (start_mdc_o) begin
        tag_mem_q[wr_ptr_q] <= tag_in_q;
        wr_ptr_q            <= wr_ptr_q + FAW'(1);
        tag_in_q            <= tag_in_q + TAG_W'(1);
      end
      if (out_last_o) rd_ptr_q <= rd_ptr_q + FAW'(1);
    end
  end

  assign out_tag_o = out_valid_o ? tag_mem_q[rd_ptr_q] : '0;
  assign busy_o    = (beat_cnt_q != '0) | (|dly_q) | start_mdc_o;

endmodule

// File: tb/tb_mdc_frame_sched.sv
// Randomized scoreboard bench for mdc_frame_sched: a frame-level model predicts admissions,
// and a separate monitor checks stage pulses and output framing against queued expectations.
module tb_mdc_frame_sched;
  localparam int BEATS = 8, LATENCY = 26, ROM0 = 3, COMM0 = 7, ROM1 = 17, COMM1 = 21;
  localparam int CREDITS = 2, TAG_W = 4;
  localparam int SPAN = LATENCY + BEATS - 1;

  logic clk = 0, rst_ni = 0, in_valid_i = 0, credit_return_i = 0, err_clr_i = 0;
  logic in_ready_o, start_mdc_o, wrom0_start_o, comm0_start_o, wrom1_start_o, comm1_start_o;
  logic out_valid_o, out_first_o, out_last_o, gap_err_o, credit_err_o, busy_o;
  logic [TAG_W-1:0] out_tag_o;

  mdc_frame_sched #(.BEATS(BEATS), .LATENCY(LATENCY), .ROM0_OFS(ROM0), .COMM0_OFS(COMM0),
    .ROM1_OFS(ROM1), .COMM1_OFS(COMM1), .CREDITS(CREDITS), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .start_mdc_o(start_mdc_o), .wrom0_start_o(wrom0_start_o), .comm0_start_o(comm0_start_o),
    .wrom1_start_o(wrom1_start_o), .comm1_start_o(comm1_start_o), .out_valid_o(out_valid_o),
    .out_first_o(out_first_o), .out_last_o(out_last_o), .out_tag_o(out_tag_o),
    .credit_return_i(credit_return_i), .err_clr_i(err_clr_i), .gap_err_o(gap_err_o),
    .credit_err_o(credit_err_o), .busy_o(busy_o));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int first; int tag; } fr_t;
  int  tq[4][$];
  fr_t q_out[$];
  int  starts[$];
  int  checks = 0, failures = 0;
  bit  done = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a pulse or output beat.
  always @(negedge clk) if (!done) begin
    logic [3:0] taps;
    taps = {comm1_start_o, wrom1_start_o, comm0_start_o, wrom0_start_o};
    if (!rst_ni) begin
      chk("rst_outputs", int'({taps, start_mdc_o, out_valid_o, out_first_o, out_last_o,
          gap_err_o, credit_err_o, busy_o}), 0);
      chk("rst_tag", int'(out_tag_o), 0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (tq[k].size() > 0 && tq[k][0] < cyc) begin
          chk($sformatf("tap%0d_missed", k), 0, 1);
          void'(tq[k].pop_front());
        end
        if (taps[k]) begin
          if (tq[k].size() == 0) chk($sformatf("tap%0d_spurious", k), cyc, -1);
          else begin
            chk($sformatf("tap%0d_cycle", k), cyc, tq[k][0]);
            void'(tq[k].pop_front());
          end
        end
      end
      if (q_out.size() > 0 && cyc >= q_out[0].first) begin
        chk("out_valid", int'(out_valid_o), 1);
        chk("out_first", int'(out_first_o), int'(cyc == q_out[0].first));
        chk("out_last",  int'(out_last_o),  int'(cyc == q_out[0].first + BEATS - 1));
        chk("out_tag",   int'(out_tag_o),   q_out[0].tag);
        if (cyc >= q_out[0].first + BEATS - 1) void'(q_out.pop_front());
      end else if (out_valid_o) begin
        chk("out_valid_spurious", 1, 0);
      end
    end
  end

  // Frame-level reference state.
  int m_phase, m_cred, m_tag;
  bit m_gap, m_cerr;

  task automatic model_reset();
    m_phase = 0; m_cred = CREDITS; m_tag = 0; m_gap = 0; m_cerr = 0;
    for (int k = 0; k < 4; k++) tq[k].delete();
    q_out.delete();
    starts.delete();
  endtask

  initial begin
    int pv, pr, T;
    bit exp_ready, exp_start, exp_busy, vin, ret, clr;
    model_reset();
    for (int n = 0; n < 1300; n++) begin
      @(posedge clk); #1;
      rst_ni = !(n < 3 || (n >= 400 && n < 403));
      if (n < 400)       begin pv = 90; pr = 15; end
      else if (n < 800)  begin pv = 70; pr = 30; end
      else if (n < 1230) begin pv = 97; pr = 6;  end
      else               begin pv = 0;  pr = 0;  end
      vin = ($urandom_range(0, 99) < pv);
      ret = ($urandom_range(0, 99) < pr);
      clr = ($urandom_range(0, 99) < 5);
      in_valid_i = vin; credit_return_i = ret; err_clr_i = clr;
      if (!rst_ni) model_reset();
      T = cyc;
      exp_ready = (m_phase != 0) || (m_cred > 0);
      exp_start = rst_ni && (m_phase == 0) && vin && (m_cred > 0);
      if (exp_start) begin
        fr_t f;
        tq[0].push_back(T + ROM0);  tq[1].push_back(T + COMM0);
        tq[2].push_back(T + ROM1);  tq[3].push_back(T + COMM1);
        f.first = T + LATENCY; f.tag = m_tag;
        q_out.push_back(f);
      end
      while (starts.size() > 0 && starts[0] < T - SPAN) void'(starts.pop_front());
      exp_busy = exp_start || (starts.size() > 0);
      @(negedge clk);
      chk("in_ready", int'(in_ready_o), int'(exp_ready));
      if (rst_ni) begin
        chk("start_mdc", int'(start_mdc_o), int'(exp_start));
        chk("gap_err", int'(gap_err_o), int'(m_gap));
        chk("credit_err", int'(credit_err_o), int'(m_cerr));
        chk("busy", int'(busy_o), int'(exp_busy));
        if (m_phase != 0 && !vin) m_gap = 1;
        else if (clr)             m_gap = 0;
        if (ret && !exp_start && m_cred == CREDITS) m_cerr = 1;
        else if (clr)                               m_cerr = 0;
        if (ret && !exp_start && m_cred < CREDITS) m_cred++;
        else if (exp_start && !ret)                m_cred--;
        if (exp_start) begin
          m_phase = 1; m_tag = (m_tag + 1) % (1 << TAG_W);
          starts.push_back(T);
        end else if (m_phase != 0) m_phase = (m_phase + 1) % BEATS;
      end
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("tap%0d_leftover", k), tq[k].size(), 0);
    chk("out_leftover", q_out.size(), 0);
    chk("final_busy", int'(busy_o), 0);
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
